m_mem_arb: RTL and testbench

M_MEM_ARB -- requirements
Module: m_mem_arb

---
 rtl/m_mem_arb.sv | 139 +++++++++++++
 tb/tb_m_mem_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_arb.sv
// Single-port memory arbiter between an instruction-fetch requester and a
// load/store requester. One access in flight at a time; data has priority
// over fetch unless fetch has waited through STARVE consecutive data grants.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access in flight; any request is granted and issued now
// S_WAIT | access issued, counting down the memory read latency
module m_mem_arb #(
    parameter int LAT    = 1,
    parameter int STARVE = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_ireq,
    input  logic [31:0] w_iaddr,
    output logic        w_igrant,
    output logic        w_ivalid,
    output logic [31:0] w_irdata,
    input  logic        w_dreq,
    input  logic        w_dwe,
    input  logic [31:0] w_daddr,
    input  logic [31:0] w_dwdata,
    output logic        w_dgrant,
    output logic        w_dvalid,
    output logic [31:0] w_drdata,
    output logic        w_men,
    output logic        w_mwe,
    output logic [31:0] w_maddr,
    output logic [31:0] w_mwdata,
    input  logic [31:0] w_mrdata
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    // Latency counter is loaded so that it reaches zero on the cycle the
    // memory read data is valid.
    localparam logic [1:0] LAT_LOAD   = 2'(LAT - 1);
    localparam logic [2:0] STARVE_MAX = 3'(STARVE);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_cnt;
    logic [2:0] starve_cnt;
    logic       own_fetch;
    logic       own_store;
    logic       fetch_win;
    logic       mem_done;

    assign fetch_win = w_ireq && (!w_dreq || (starve_cnt == STARVE_MAX));
    assign mem_done  = (state == S_WAIT) && (lat_cnt == 2'd0);

    // Next state plus Mealy grant/issue; grants are gated by reset so they
    // drop immediately when reset asserts.
    always_comb begin
        state_nxt = state;
        w_igrant  = 1'b0;
        w_dgrant  = 1'b0;
        w_men     = 1'b0;
        w_mwe     = 1'b0;
        w_maddr   = w_daddr;
        w_mwdata  = w_dwdata;
        case (state)
            S_IDLE: begin
                if (w_rst_n && (w_ireq || w_dreq)) begin
                    w_men     = 1'b1;
                    state_nxt = S_WAIT;
                    if (fetch_win) begin
                        w_igrant = 1'b1;
                        w_maddr  = w_iaddr;
                    end else begin
                        w_dgrant = 1'b1;
                        w_mwe    = w_dwe;
                    end
                end
            end
            S_WAIT: begin
                if (mem_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Read-latency down-counter, loaded on issue.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            lat_cnt <= 2'd0;
        end else if (w_men) begin
            lat_cnt <= LAT_LOAD;
        end else if ((state == S_WAIT) && (lat_cnt != 2'd0)) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    // Starvation counter: consecutive data grants while fetch is waiting.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            starve_cnt <= 3'd0;
        end else if (w_igrant) begin
            starve_cnt <= 3'd0;
        end else if (w_dgrant) begin
            if (!w_ireq)                       starve_cnt <= 3'd0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Remember who owns the in-flight access and whether it is a store.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            own_fetch <= 1'b0;
            own_store <= 1'b0;
        end else if (w_men) begin
            own_fetch <= w_igrant;
            own_store <= w_dgrant && w_dwe;
        end
    end

    // Capture read data for the owner and pulse its valid one cycle later.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_ivalid <= 1'b0;
            w_dvalid <= 1'b0;
            w_irdata <= 32'd0;
            w_drdata <= 32'd0;
        end else begin
            w_ivalid <= mem_done && own_fetch;
            w_dvalid <= mem_done && !own_fetch;
            if (mem_done && own_fetch)               w_irdata <= w_mrdata;
            if (mem_done && !own_fetch && !own_store) w_drdata <= w_mrdata;
        end
    end

endmodule

// File: tb/tb_m_mem_arb.sv
// Bench for m_mem_arb: two instances (LAT=1 and LAT=3) with a cycle-level
// transaction model, a memory model driving w_mrdata only on the valid cycle,
// and directed scenarios with literal expectations.
module tb_m_mem_arb;

    localparam int STARVE = 4;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ireq[2], dreq[2], dwe[2];
    logic [31:0] iaddr[2], daddr[2], dwdata[2], mrdata[2];
    logic        igrant[2], ivalid[2], dgrant[2], dvalid[2], men[2], mwe[2];
    logic [31:0] irdata[2], drdata[2], maddr[2], mwdata[2];

    m_mem_arb #(.LAT(LAT0), .STARVE(STARVE)) u_dut0 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_ireq(ireq[0]), .w_iaddr(iaddr[0]), .w_igrant(igrant[0]),
        .w_ivalid(ivalid[0]), .w_irdata(irdata[0]),
        .w_dreq(dreq[0]), .w_dwe(dwe[0]), .w_daddr(daddr[0]), .w_dwdata(dwdata[0]),
        .w_dgrant(dgrant[0]), .w_dvalid(dvalid[0]), .w_drdata(drdata[0]),
        .w_men(men[0]), .w_mwe(mwe[0]), .w_maddr(maddr[0]), .w_mwdata(mwdata[0]),
        .w_mrdata(mrdata[0])
    );

    m_mem_arb #(.LAT(LAT1), .STARVE(STARVE)) u_dut1 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_ireq(ireq[1]), .w_iaddr(iaddr[1]), .w_igrant(igrant[1]),
        .w_ivalid(ivalid[1]), .w_irdata(irdata[1]),
        .w_dreq(dreq[1]), .w_dwe(dwe[1]), .w_daddr(daddr[1]), .w_dwdata(dwdata[1]),
        .w_dgrant(dgrant[1]), .w_dvalid(dvalid[1]), .w_drdata(drdata[1]),
        .w_men(men[1]), .w_mwe(mwe[1]), .w_maddr(maddr[1]), .w_mwdata(mwdata[1]),
        .w_mrdata(mrdata[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [2][64];
    int          free_at[2], cap_at[2], done_at[2], starve[2];
    bit          own_f[2], own_st[2];
    logic [31:0] cap_addr[2], exp_ir[2], exp_dr[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // Every cycle: outputs against the model, then advance the model and
    // drive memory read data only on the cycle it is valid (junk otherwise).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          e_f, e_d, e_iv, e_dv, free;
            logic [31:0] rd;
            if (!rst_n) begin
                free_at[i] = 0; cap_at[i] = -1; done_at[i] = -1; starve[i] = 0;
                exp_ir[i] = 32'd0; exp_dr[i] = 32'd0; own_f[i] = 1'b0; own_st[i] = 1'b0;
                chk1($sformatf("rst%0d_igrant", i), igrant[i], 1'b0);
                chk1($sformatf("rst%0d_dgrant", i), dgrant[i], 1'b0);
                chk1($sformatf("rst%0d_men", i), men[i], 1'b0);
                chk1($sformatf("rst%0d_ivalid", i), ivalid[i], 1'b0);
                chk1($sformatf("rst%0d_dvalid", i), dvalid[i], 1'b0);
                chk32($sformatf("rst%0d_irdata", i), irdata[i], 32'd0);
                chk32($sformatf("rst%0d_drdata", i), drdata[i], 32'd0);
                mrdata[i] = {16'hDEAD, cyc[15:0]};
            end else begin
                e_iv = (cyc == done_at[i]) && own_f[i];
                e_dv = (cyc == done_at[i]) && !own_f[i];
                chk1($sformatf("m%0d_ivalid", i), ivalid[i], e_iv);
                chk1($sformatf("m%0d_dvalid", i), dvalid[i], e_dv);
                chk32($sformatf("m%0d_irdata", i), irdata[i], exp_ir[i]);
                chk32($sformatf("m%0d_drdata", i), drdata[i], exp_dr[i]);
                free = (cyc >= free_at[i]);
                e_f  = free && ireq[i] && (!dreq[i] || starve[i] == STARVE);
                e_d  = free && dreq[i] && !e_f;
                chk1($sformatf("m%0d_igrant", i), igrant[i], e_f);
                chk1($sformatf("m%0d_dgrant", i), dgrant[i], e_d);
                chk1($sformatf("m%0d_men", i), men[i], e_f | e_d);
                if (e_f) begin
                    chk32($sformatf("m%0d_maddr_f", i), maddr[i], iaddr[i]);
                    chk1($sformatf("m%0d_mwe_f", i), mwe[i], 1'b0);
                end
                if (e_d) begin
                    chk32($sformatf("m%0d_maddr_d", i), maddr[i], daddr[i]);
                    chk1($sformatf("m%0d_mwe_d", i), mwe[i], dwe[i]);
                    if (dwe[i]) chk32($sformatf("m%0d_mwdata", i), mwdata[i], dwdata[i]);
                end
                if (e_f || e_d) begin
                    cap_at[i]   = cyc + lat_of(i);
                    done_at[i]  = cap_at[i] + 1;
                    free_at[i]  = done_at[i];
                    own_f[i]    = e_f;
                    own_st[i]   = e_d && dwe[i];
                    cap_addr[i] = e_f ? iaddr[i] : daddr[i];
                    if (own_st[i]) mem[i][daddr[i][7:2]] = dwdata[i];
                end
                if (e_f) starve[i] = 0;
                else if (e_d) starve[i] = !ireq[i] ? 0 : ((starve[i] < STARVE) ? starve[i] + 1 : STARVE);
                if (cyc == cap_at[i]) begin
                    rd = mem[i][cap_addr[i][7:2]];
                    mrdata[i] = rd;
                    if (!own_st[i]) begin
                        if (own_f[i]) exp_ir[i] = rd;
                        else          exp_dr[i] = rd;
                    end
                end else begin
                    mrdata[i] = {16'hDEAD, cyc[15:0]};
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_grant(input int idx, output bit ok, output bit isf);
        ok  = 1'b0;
        isf = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (!ok) begin
                #1;
                if (igrant[idx] || dgrant[idx]) begin
                    ok  = 1'b1;
                    isf = igrant[idx];
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, isf;
        int np;
        for (int i = 0; i < 2; i++) begin
            ireq[i] = 1'b0; dreq[i] = 1'b0; dwe[i] = 1'b0;
            iaddr[i] = 32'd0; daddr[i] = 32'd0; dwdata[i] = 32'd0;
            for (int a = 0; a < 64; a++) mem[i][a] = 32'h0;
        end
        mem[0][0] = 32'h0070_0093;
        mem[0][4] = 32'h1234_5678;
        mem[1][2] = 32'h0000_0007;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk32("reset_irdata", irdata[0], 32'd0);
        chk32("reset_drdata", drdata[0], 32'd0);

        // Fetch with LAT=1.
        step(); ireq[0] = 1'b1; iaddr[0] = 32'h0; #1;
        chk1("a_igrant", igrant[0], 1'b1);
        chk1("a_men", men[0], 1'b1);
        chk32("a_maddr", maddr[0], 32'h0);
        step(); ireq[0] = 1'b0;
        step(); #1;
        chk1("a_ivalid", ivalid[0], 1'b1);
        chk32("a_irdata", irdata[0], 32'h0070_0093);

        // Load at 0x10; issued in the same cycle the fetch valid pulses.
        dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 32'h10; #1;
        chk1("a2_dgrant", dgrant[0], 1'b1);
        step(); dreq[0] = 1'b0;
        step(); #1;
        chk1("a2_dvalid", dvalid[0], 1'b1);
        chk32("a2_drdata", drdata[0], 32'h1234_5678);

        // Store vs fetch at the same time: data wins.
        step(); ireq[0] = 1'b1; iaddr[0] = 32'h4;
        dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 32'h20; dwdata[0] = 32'd7; #1;
        chk1("b_dgrant", dgrant[0], 1'b1);
        chk1("b_igrant0", igrant[0], 1'b0);
        chk1("b_mwe", mwe[0], 1'b1);
        chk32("b_mwdata", mwdata[0], 32'd7);
        step(); dreq[0] = 1'b0; dwe[0] = 1'b0; #1;
        chk1("b_igrant_wait", igrant[0], 1'b0);
        step(); #1;
        chk1("b_dvalid", dvalid[0], 1'b1);
        chk1("b_igrant2", igrant[0], 1'b1);
        chk32("b_drdata_kept", drdata[0], 32'h1234_5678);
        step(); ireq[0] = 1'b0;
        repeat (2) step();

        // Read back the stored word.
        dreq[0] = 1'b1; daddr[0] = 32'h20; #1;
        chk1("b2_dgrant", dgrant[0], 1'b1);
        step(); dreq[0] = 1'b0;
        step(); #1;
        chk32("b2_drdata", drdata[0], 32'd7);
        repeat (2) step();

        // Both requesters held: 4 data grants, then a fetch, repeating.
        ireq[0] = 1'b1; iaddr[0] = 32'h0; dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 32'h10;
        for (int k = 0; k < 10; k++) begin
            next_grant(0, ok, isf);
            chk1($sformatf("c_grant%0d_seen", k), ok, 1'b1);
            chk1($sformatf("c_grant%0d_fetch", k), isf, (k % 5) == 4);
        end
        ireq[0] = 1'b0; dreq[0] = 1'b0;
        repeat (3) step();

        // LAT=3 load; requests during the wait are ignored.
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 32'h8; #1;
        chk1("d_dgrant", dgrant[1], 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step(); dreq[1] = 1'b1; #1;
            chk1($sformatf("d_nogrant%0d", k), dgrant[1], 1'b0);
            chk1($sformatf("d_nomen%0d", k), men[1], 1'b0);
        end
        step(); dreq[1] = 1'b0; #1;
        chk1("d_dvalid", dvalid[1], 1'b1);
        chk32("d_drdata", drdata[1], 32'h7);
        repeat (2) step();

        // Reset in the middle of a LAT=3 load.
        dreq[1] = 1'b1; daddr[1] = 32'h8; #1;
        chk1("e_dgrant", dgrant[1], 1'b1);
        step(); dreq[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("e_rst_men", men[1], 1'b0);
        chk1("e_rst_dvalid", dvalid[1], 1'b0);
        chk32("e_rst_drdata", drdata[1], 32'd0);
        chk32("e_rst_irdata0", irdata[0], 32'd0);
        step(); dreq[1] = 1'b1; #1;
        chk1("e_rst_gate", dgrant[1], 1'b0);
        step(); rst_n = 1'b1; #1;
        chk1("e_first_grant", dgrant[1], 1'b1);
        step(); dreq[1] = 1'b0;
        np = 0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (dvalid[1]) np++;
            step();
        end
        chk32("e_dvalid_count", 32'(np), 32'd1);
        chk32("e_drdata_after", drdata[1], 32'h7);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
